// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Width of a counter that must reach max(a,b,c)-1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases the core reset.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRIES      = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               soft_reset,
  output logic               pll_rst,
  output logic               core_reset,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic               lock_lost
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] MAX_R        = RETRY_W'(MAX_RETRIES);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost_nxt;
  logic               locked_s;

  sync_2ff u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );

  // soft_reset overrides every transition, including a lock loss seen in RUN.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    lost_nxt  = 1'b0;
    if (soft_reset) begin
      state_nxt = PLL_RST;
      retry_nxt = '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == PULSE_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_count == MAX_R) begin
              state_nxt = FAIL;
            end else begin
              state_nxt = PLL_RST;
              retry_nxt = retry_count + 1'b1;
            end
          end
        end
        STABLE: begin
          if (!locked_s) state_nxt = WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nxt = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = PLL_RST;
            retry_nxt = '0;
            lost_nxt  = 1'b1;
          end
        end
        FAIL:    state_nxt = FAIL;
        default: state_nxt = PLL_RST;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      core_reset  <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (soft_reset || state_nxt != state) ? '0 : cnt + 1'b1;
      retry_count <= retry_nxt;
      pll_rst     <= (state_nxt == PLL_RST);
      core_reset  <= (state_nxt != RUN);
      ready       <= (state_nxt == RUN);
      fail        <= (state_nxt == FAIL);
      lock_lost   <= lost_nxt;
    end
  end

endmodule
